// File: rtl/sleepwell_pkg.sv
// Shared constants for the bouncing-ball renderer: default raster size,
// palette and motion FSM encoding.
package sleepwell_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [5:0] COLOR_OFF    = 6'b00_00_00;
  localparam logic [5:0] COLOR_SHADOW = 6'b01_01_01;
  localparam logic [5:0] COLOR_BG     = 6'b00_00_10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } motion_state_t;

  function automatic logic [5:0] ball_color(input logic [1:0] index);
    case (index)
      2'd0:    return 6'b11_10_00;
      2'd1:    return 6'b11_00_11;
      2'd2:    return 6'b00_11_11;
      default: return 6'b11_11_11;
    endcase
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis position step with bounce: clamps to [min,max] and flips direction
// when the step would reach or cross a limit.
module ball_axis_step (
  input  logic [9:0] pos,
  input  logic       dir,
  input  logic [2:0] step,
  input  logic [9:0] min,
  input  logic [9:0] max,
  output logic [9:0] next_pos,
  output logic       next_dir
);

  logic [10:0] up_next;
  logic [10:0] low_limit_next;

  // 11-bit sums so neither edge test can wrap
  assign up_next        = {1'b0, pos} + {8'b0, step};
  assign low_limit_next = {1'b0, min} + {8'b0, step};

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    if (dir) begin
      if (up_next >= {1'b0, max}) begin
        next_pos = max;
        next_dir = 1'b0;
      end else begin
        next_pos = up_next[9:0];
      end
    end else begin
      if ({1'b0, pos} <= low_limit_next) begin
        next_pos = min;
        next_dir = 1'b1;
      end else begin
        next_pos = pos - {7'b0, step};
      end
    end
  end

endmodule

// File: rtl/multi_ball_renderer.sv
// Up to four bouncing balls with a shadow ring; positions advance once per
// frame in vertical blanking, pixels go through a 2-stage distance pipeline.
module multi_ball_renderer
  import sleepwell_pkg::*;
#(
  parameter int NUM_BALLS     = 4,
  parameter int BALL_RADIUS   = 20,
  parameter int SHADOW_MARGIN = 4,
  parameter int H_ACTIVE      = H_ACTIVE_DEF,
  parameter int V_ACTIVE      = V_ACTIVE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       pause,
  input  logic [1:0] speed_sel,
  output logic [5:0] rgb,
  output logic       busy
);

  localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);
  localparam logic [9:0]  X_MIN = 10'(BALL_RADIUS);
  localparam logic [9:0]  X_MAX = 10'(H_ACTIVE - 1 - BALL_RADIUS);
  localparam logic [9:0]  Y_MIN = 10'(BALL_RADIUS);
  localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - 1 - BALL_RADIUS);
  localparam logic [20:0] R2    = 21'(BALL_RADIUS * BALL_RADIUS);
  localparam logic [20:0] S2    = 21'((BALL_RADIUS + SHADOW_MARGIN) * (BALL_RADIUS + SHADOW_MARGIN));

  motion_state_t    state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [9:0]       ball_x_reg [NUM_BALLS];
  logic [9:0]       ball_y_reg [NUM_BALLS];
  logic             ball_x_dir_reg [NUM_BALLS];
  logic             ball_y_dir_reg [NUM_BALLS];

  logic       frame_tick;
  logic [2:0] step_next;
  logic [9:0] x_next, y_next;
  logic       x_dir_next, y_dir_next;

  assign frame_tick = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));
  assign step_next  = {1'b0, speed_sel} + 3'd1;

  ball_axis_step u_x_step (
    .pos      (ball_x_reg[idx_reg]),
    .dir      (ball_x_dir_reg[idx_reg]),
    .step     (step_next),
    .min      (X_MIN),
    .max      (X_MAX),
    .next_pos (x_next),
    .next_dir (x_dir_next)
  );

  ball_axis_step u_y_step (
    .pos      (ball_y_reg[idx_reg]),
    .dir      (ball_y_dir_reg[idx_reg]),
    .step     (step_next),
    .min      (Y_MIN),
    .max      (Y_MAX),
    .next_pos (y_next),
    .next_dir (y_dir_next)
  );

  // Motion FSM; ticks are only accepted in IDLE, so a tick while busy is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        ball_x_reg[i]     <= 10'(160 + 80 * i);
        ball_y_reg[i]     <= 10'(120 + 60 * i);
        ball_x_dir_reg[i] <= ~i[0];
        ball_y_dir_reg[i] <= 1'b1;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (frame_tick && !pause) begin
            state_reg <= ST_UPDATE;
            idx_reg   <= '0;
            busy      <= 1'b1;
          end
        end
        ST_UPDATE: begin
          ball_x_reg[idx_reg]     <= x_next;
          ball_y_reg[idx_reg]     <= y_next;
          ball_x_dir_reg[idx_reg] <= x_dir_next;
          ball_y_dir_reg[idx_reg] <= y_dir_next;
          if (idx_reg == LAST_IDX) begin
            state_reg <= ST_DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  logic [20:0] d2_next [NUM_BALLS];
  logic [20:0] d2_reg  [NUM_BALLS];
  logic        de_reg;

  // Squared distance via absolute differences keeps the multipliers unsigned
  for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_dist
    logic [10:0] dx, dy;
    logic [9:0]  adx, ady;
    logic [19:0] sqx, sqy;
    assign dx  = {1'b0, hpos} - {1'b0, ball_x_reg[gi]};
    assign dy  = {1'b0, vpos} - {1'b0, ball_y_reg[gi]};
    assign adx = dx[10] ? 10'(-dx) : dx[9:0];
    assign ady = dy[10] ? 10'(-dy) : dy[9:0];
    assign sqx = adx * adx;
    assign sqy = ady * ady;
    assign d2_next[gi] = {1'b0, sqx} + {1'b0, sqy};
  end

  logic [5:0] rgb_next;
  logic [5:0] ball_rgb;
  logic       ball_hit;
  logic       shadow_hit;

  always_comb begin
    rgb_next   = COLOR_OFF;
    ball_rgb   = COLOR_OFF;
    ball_hit   = 1'b0;
    shadow_hit = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (!ball_hit && (d2_reg[i] <= R2)) begin
        ball_hit = 1'b1;
        ball_rgb = ball_color(2'(i));
      end
      if (d2_reg[i] <= S2) begin
        shadow_hit = 1'b1;
      end
    end
    if (de_reg) begin
      rgb_next = ball_hit ? ball_rgb : (shadow_hit ? COLOR_SHADOW : COLOR_BG);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        d2_reg[i] <= '0;
      end
      de_reg <= 1'b0;
      rgb    <= COLOR_OFF;
    end else begin
      d2_reg <= d2_next;
      de_reg <= display_on;
      rgb    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_multi_ball_renderer.sv
// Randomised bench: a positional model of the four balls predicts every pixel
// and the busy window; literal pixel probes pin the model at known positions.
module tb_multi_ball_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       display_on, pause;
  logic [1:0] speed_sel;
  logic [5:0] rgb;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int mx [4];
  int my [4];
  int mxd [4];
  int myd [4];

  multi_ball_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .pause      (pause),
    .speed_sel  (speed_sel),
    .rgb        (rgb),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [5:0] colour_of(input int i);
    case (i)
      0:       return 6'b11_10_00;
      1:       return 6'b11_00_11;
      2:       return 6'b00_11_11;
      default: return 6'b11_11_11;
    endcase
  endfunction

  function automatic logic [5:0] model_rgb(input int h, input int v, input bit de);
    int d2;
    if (!de) return 6'b0;
    for (int i = 0; i < 4; i++) begin
      d2 = (h - mx[i]) * (h - mx[i]) + (v - my[i]) * (v - my[i]);
      if (d2 <= 400) return colour_of(i);
    end
    for (int i = 0; i < 4; i++) begin
      d2 = (h - mx[i]) * (h - mx[i]) + (v - my[i]) * (v - my[i]);
      if (d2 <= 576) return 6'b01_01_01;
    end
    return 6'b00_00_10;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 160 + 80 * i;
      my[i] = 120 + 60 * i;
      mxd[i] = (i % 2 == 0) ? 1 : 0;
      myd[i] = 1;
    end
  endtask

  task automatic model_advance(input int s);
    for (int i = 0; i < 4; i++) begin
      if (mxd[i] == 1) begin
        if (mx[i] + s >= 619) begin mx[i] = 619; mxd[i] = 0; end
        else mx[i] = mx[i] + s;
      end else begin
        if (mx[i] <= 20 + s) begin mx[i] = 20; mxd[i] = 1; end
        else mx[i] = mx[i] - s;
      end
      if (myd[i] == 1) begin
        if (my[i] + s >= 459) begin my[i] = 459; myd[i] = 0; end
        else my[i] = my[i] + s;
      end else begin
        if (my[i] <= 20 + s) begin my[i] = 20; myd[i] = 1; end
        else my[i] = my[i] - s;
      end
    end
  endtask

  // Expected outputs: rgb two clocks behind the pixel, busy for 5 clocks after an accepted tick
  logic [5:0] exp0, exp1;
  int busy_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp0 <= 6'b0;
      exp1 <= 6'b0;
      busy_cnt <= 0;
    end else begin
      exp0 <= model_rgb(int'(hpos), int'(vpos), display_on);
      exp1 <= exp0;
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      else if (hpos == 10'd0 && vpos == 10'd480 && !pause) busy_cnt <= 5;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      checks++;
      if (rgb !== exp1) begin
        errors++;
        $display("FAIL rgb_model t=%0t got %b want %b", $time, rgb, exp1);
      end
      checks++;
      if (busy !== (busy_cnt > 0)) begin
        errors++;
        $display("FAIL busy_model t=%0t got %b want %b", $time, busy, (busy_cnt > 0));
      end
    end
  end

  task automatic px(input int h, input int v, input bit de);
    hpos = 10'(h);
    vpos = 10'(v);
    display_on = de;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int sel, input bit p, output int bc);
    speed_sel = 2'(sel);
    pause = p;
    px(0, 480, 0);
    if (!p) model_advance(sel + 1);
    bc = 0;
    for (int k = 0; k < 7; k++) begin
      if (busy === 1'b1) bc++;
      px(1, 481, 0);
    end
    pause = 1'b0;
    $display("tick sel=%0d pause=%0d busy_cycles=%0d ball0=(%0d,%0d)", sel, p, bc, mx[0], my[0]);
  endtask

  task automatic pin(input string name, input int h, input int v, input bit de, input logic [5:0] want);
    px(h, v, de);
    px(1, 481, 0);
    checks++;
    if (rgb !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, rgb, want);
    end else begin
      $display("pixel %s (%0d,%0d) rgb=%b", name, h, v, rgb);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end else begin
      $display("check %s = %0d", name, got);
    end
  endtask

  task automatic random_probes(input int n);
    int b, h, v;
    bit de;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        h = $urandom_range(0, 639);
        v = $urandom_range(0, 479);
      end else begin
        b = $urandom_range(0, 3);
        h = mx[b] + $urandom_range(0, 60) - 30;
        v = my[b] + $urandom_range(0, 60) - 30;
      end
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      if (v > 479) v = 479;
      de = ($urandom_range(0, 7) != 0);
      px(h, v, de);
    end
  endtask

  initial begin
    int bc, guard, sel, vv;
    rst_n = 1'b0;
    hpos = 10'd0;
    vpos = 10'd0;
    display_on = 1'b0;
    pause = 1'b0;
    speed_sel = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rgb !== 6'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rgb=%b busy=%b want rgb=000000 busy=0", rgb, busy);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;
    px(1, 481, 0);

    // Pixel classes around ball 0 at its reset position
    pin("ball0_centre", 160, 120, 1, 6'b11_10_00);
    pin("ball0_dist22", 182, 120, 1, 6'b01_01_01);
    pin("ball0_dist30", 190, 120, 1, 6'b00_00_10);
    pin("display_off", 160, 120, 0, 6'b00_00_00);

    // First tick after release with speed_sel=1
    tick(1, 0, bc);
    check_int("first_tick_busy_cycles", bc, 5);
    pin("b0_right_edge", 182, 122, 1, 6'b11_10_00);
    pin("b0_left_edge", 142, 122, 1, 6'b11_10_00);
    pin("b0_top_edge", 162, 102, 1, 6'b11_10_00);
    pin("b0_bottom_edge", 162, 142, 1, 6'b11_10_00);
    pin("b0_dist21", 183, 122, 1, 6'b01_01_01);
    pin("b1_right_edge", 258, 182, 1, 6'b11_00_11);
    pin("b1_left_edge", 218, 182, 1, 6'b11_00_11);

    // Paused ticks are ignored
    for (int k = 0; k < 3; k++) begin
      tick(2, 1, bc);
      check_int("paused_busy_cycles", bc, 0);
    end
    pin("paused_b0_edge", 182, 122, 1, 6'b11_10_00);
    pin("paused_b0_out", 183, 122, 1, 6'b01_01_01);
    tick(2, 0, bc);
    pin("resume_b0_right", 185, 125, 1, 6'b11_10_00);
    pin("resume_b0_left", 145, 125, 1, 6'b11_10_00);

    // Walk ball 0 to x=617 heading right, then bounce it off the right limit
    guard = 0;
    while (mx[0] != 617 && guard < 200) begin
      sel = (617 - mx[0] >= 4) ? 3 : (617 - mx[0] - 1);
      tick(sel, 0, bc);
      random_probes(6);
      guard++;
    end
    check_int("b0_reached_617_model", mx[0], 617);
    vv = my[0];
    pin("x617_left", 597, vv, 1, 6'b11_10_00);
    pin("x617_right", 637, vv, 1, 6'b11_10_00);
    tick(3, 0, bc);
    vv = my[0];
    pin("x619_left", 599, vv, 1, 6'b11_10_00);
    pin("x619_right", 639, vv, 1, 6'b11_10_00);
    tick(3, 0, bc);
    vv = my[0];
    pin("x615_left", 595, vv, 1, 6'b11_10_00);
    pin("x615_right", 635, vv, 1, 6'b11_10_00);

    // Random frames
    for (int f = 0; f < 40; f++) begin
      tick($urandom_range(0, 3), ($urandom_range(0, 4) == 0), bc);
      random_probes(40);
    end

    // Reset while ball index 2 is being processed
    speed_sel = 2'd1;
    px(0, 480, 0);
    px(1, 481, 0);
    px(1, 481, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || rgb !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_update got busy=%b rgb=%b want busy=0 rgb=000000", busy, rgb);
    end else begin
      $display("reset_mid_update busy=%b rgb=%b", busy, rgb);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    px(1, 481, 0);
    pin("rst_b0_right", 180, 120, 1, 6'b11_10_00);
    pin("rst_b0_left", 140, 120, 1, 6'b11_10_00);
    pin("rst_b1_centre", 240, 180, 1, 6'b11_00_11);
    pin("rst_b2_edge", 340, 240, 1, 6'b00_11_11);
    pin("rst_b3_edge", 420, 300, 1, 6'b11_11_11);
    tick(1, 0, bc);
    check_int("post_reset_busy_cycles", bc, 5);
    pin("post_reset_b0", 182, 122, 1, 6'b11_10_00);
    random_probes(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
